voting_machine: RTL and testbench
=================================

Name: voting_machine

Overview:
Three-candidate electronic ballot counter. Tallies one vote per clock cycle from three candidate inputs while in vote mode, and shows the per-candidate counts at all times. In result mode it raises one-hot/tie winner flags. It is a standalone leaf block driven by a mode selector and candidate buttons.

Parameters:
COUNT_W, 8, width of each candidate tally and count output.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
mode  input  2  0=idle, 1=vote, 2=result, 3=reserved (treated as idle)
in_candidate_1  input  1  vote request for candidate 1 (level, sampled each edge)
in_candidate_2  input  1  vote request for candidate 2
in_candidate_3  input  1  vote request for candidate 3
count_candidate_1  output  COUNT_W  registered tally, candidate 1
count_candidate_2  output  COUNT_W  registered tally, candidate 2
count_candidate_3  output  COUNT_W  registered tally, candidate 3
candidate_1  output  1  registered winner flag, candidate 1
candidate_2  output  1  registered winner flag, candidate 2
candidate_3  output  1  registered winner flag, candidate 3

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset); it has priority over everything else.
- Reset values: all counts = 0 and all winner flags = 0.
- Vote mode (mode=1):
  - On each rising edge, if exactly one in_candidate_N is 1, count_candidate_N increments by 1. The new value is visible after that same edge (latency 1 edge).
  - Inputs are level-sampled, not edge-detected. An input held high for k cycles yields k votes.
  - Zero inputs high: no change.
  - Two or three inputs high in the same cycle: invalid ballot, and no count changes.
  - Saturation: a count at 2^COUNT_W-1 (255) stays there; it does not wrap. The other counts are unaffected.
  - Winner flags are 0.
- Result mode (mode=2):
  - Counts hold.
  - On each edge, candidate_N <= 1 iff count_candidate_N equals the maximum of the three counts and that maximum is nonzero.
  - On ties, every tied candidate's flag is set.
  - If all counts are 0, all flags are 0.
  - Flags appear one edge after mode=2 is first sampled.
  - Candidate inputs are ignored.
- Idle (mode=0 or 3):
  - Counts hold and inputs are ignored.
  - Winner flags are cleared to 0 on the next edge.
- Leaving result mode:
  - Flags clear on the next edge.
  - Re-entering vote mode continues from the held counts. Only reset zeroes the counts.
- Reset mid-vote: counts are 0 after the edge where reset=1, and any vote present that cycle is discarded.
- Count outputs are driven directly from the tally registers in every mode.

Decomposition:
- Shared package voting_pkg:
  - mode constants MODE_IDLE=2'd0, MODE_VOTE=2'd1, MODE_RESULT=2'd2
  - COUNT_W default.
- One natural sub-module, vote_counter, instantiated 3 times:
  - inputs: clk, reset, inc enable
  - output: COUNT_W saturating count
- The top level holds:
  - the valid-ballot decode (exactly-one-hot check gated by mode=1)
  - the max/tie comparator
  - the winner-flag registers.

Test Plan:
- Reset: reset=1 for one edge with mode=0 -> all counts 0 and all flags 0.
- Vote sequence: mode=1, one input per cycle in order 1,3,2,1,2,2,2,3,1,1,2,3,3,2,1,3 (16 cycles) -> counts c1=5, c2=6, c3=5.
- Result: then mode=2 for 2 cycles -> after first edge candidate_2=1 and candidate_1=candidate_3=0, counts unchanged. Then mode=0 -> flags 0 next edge, counts still 5/6/5.
- Invalid and held inputs: mode=1, in1=in2=1 for 1 cycle -> no change. in3 held 3 cycles -> c3 +3.
- Tie and empty: counts 2/2/1 then mode=2 -> candidate_1=candidate_2=1, candidate_3=0. After reset, mode=2 -> all flags 0.
- Saturation and mid-run reset: in1 held 300 cycles -> c1=255 and stays. Reset asserted during voting with in2=1 -> all counts 0 the next cycle, no vote counted.

Source files
------------

// File: rtl/voting_pkg.sv
// Shared definitions for the three-candidate ballot counter: mode encodings,
// the default tally width, and the valid-ballot test.
package voting_pkg;

    // Default width of each candidate tally.
    localparam int unsigned DEFAULT_COUNT_W = 8;

    // Mode selector encodings; 2'd3 is reserved and behaves like idle.
    localparam logic [1:0] MODE_IDLE   = 2'd0;
    localparam logic [1:0] MODE_VOTE   = 2'd1;
    localparam logic [1:0] MODE_RESULT = 2'd2;

    // A ballot is valid only when exactly one candidate button is pressed.
    function automatic logic is_one_hot3(input logic [2:0] v);
        return (v != 3'b000) && ((v & (v - 3'd1)) == 3'b000);
    endfunction

endpackage

// File: rtl/vote_counter.sv
// Single candidate tally: increments by one per enabled cycle and saturates
// at its all-ones value instead of wrapping.
module vote_counter #(
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    output logic [COUNT_W-1:0] count
);

    // Synchronous clear, otherwise count up unless already saturated.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/voting_machine.sv
// Three-candidate electronic ballot counter. Counts one valid (one-hot)
// ballot per cycle in vote mode and raises registered winner flags, with
// all tied leaders flagged, in result mode.
module voting_machine
    import voting_pkg::*;
#(
    parameter int unsigned COUNT_W = DEFAULT_COUNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         mode,
    input  logic               in_candidate_1,
    input  logic               in_candidate_2,
    input  logic               in_candidate_3,
    output logic [COUNT_W-1:0] count_candidate_1,
    output logic [COUNT_W-1:0] count_candidate_2,
    output logic [COUNT_W-1:0] count_candidate_3,
    output logic               candidate_1,
    output logic               candidate_2,
    output logic               candidate_3
);

    logic [2:0]         votes;
    logic               valid_ballot;
    logic [2:0]         inc;
    logic [COUNT_W-1:0] max_count;
    logic [2:0]         win;

    assign votes        = {in_candidate_3, in_candidate_2, in_candidate_1};
    assign valid_ballot = (mode == MODE_VOTE) && is_one_hot3(votes);
    assign inc          = valid_ballot ? votes : 3'b000;

    vote_counter #(.COUNT_W(COUNT_W)) u_counter_1 (
        .clk   (clk),
        .reset (reset),
        .inc   (inc[0]),
        .count (count_candidate_1)
    );

    vote_counter #(.COUNT_W(COUNT_W)) u_counter_2 (
        .clk   (clk),
        .reset (reset),
        .inc   (inc[1]),
        .count (count_candidate_2)
    );

    vote_counter #(.COUNT_W(COUNT_W)) u_counter_3 (
        .clk   (clk),
        .reset (reset),
        .inc   (inc[2]),
        .count (count_candidate_3)
    );

    // Find the leading tally and flag every candidate that matches it;
    // an all-zero field has no winner.
    always_comb begin
        max_count = count_candidate_1;
        if (count_candidate_2 > max_count) max_count = count_candidate_2;
        if (count_candidate_3 > max_count) max_count = count_candidate_3;
        win = 3'b000;
        if (max_count != '0) begin
            win[0] = (count_candidate_1 == max_count);
            win[1] = (count_candidate_2 == max_count);
            win[2] = (count_candidate_3 == max_count);
        end
    end

    // Winner flags are only live in result mode and clear on any other mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            {candidate_3, candidate_2, candidate_1} <= 3'b000;
        end else if (mode == MODE_RESULT) begin
            {candidate_3, candidate_2, candidate_1} <= win;
        end else begin
            {candidate_3, candidate_2, candidate_1} <= 3'b000;
        end
    end

endmodule

// File: tb/tb_voting_machine.sv
// Scoreboard bench for voting_machine: a stimulus process drives directed and
// random ballots, a reference model pushes the expected post-edge outputs into
// a queue, and a monitor pops and compares them after every clock edge.
module tb_voting_machine;
    import voting_pkg::*;

    localparam int unsigned W    = 8;
    localparam int          MAXC = (1 << W) - 1;

    typedef struct packed {
        logic [W-1:0] c1;
        logic [W-1:0] c2;
        logic [W-1:0] c3;
        logic         f1;
        logic         f2;
        logic         f3;
    } obs_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   mode;
    logic         in_candidate_1, in_candidate_2, in_candidate_3;
    logic [W-1:0] count_candidate_1, count_candidate_2, count_candidate_3;
    logic         candidate_1, candidate_2, candidate_3;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference state: plain integer tallies and winner flags.
    int mc[3];
    bit mf[3];

    voting_machine #(.COUNT_W(W)) dut (
        .clk               (clk),
        .reset             (reset),
        .mode              (mode),
        .in_candidate_1    (in_candidate_1),
        .in_candidate_2    (in_candidate_2),
        .in_candidate_3    (in_candidate_3),
        .count_candidate_1 (count_candidate_1),
        .count_candidate_2 (count_candidate_2),
        .count_candidate_3 (count_candidate_3),
        .candidate_1       (candidate_1),
        .candidate_2       (candidate_2),
        .candidate_3       (candidate_3)
    );

    always #5 clk = ~clk;

    // Ballot rules: reset wins; result mode flags all leaders of a nonzero
    // maximum; a vote with exactly one pressed button adds one, capped.
    function automatic void model_step(input bit r, input logic [1:0] m, input logic [2:0] v);
        int mx;
        int pressed;
        if (r) begin
            for (int i = 0; i < 3; i++) begin
                mc[i] = 0;
                mf[i] = 1'b0;
            end
        end else if (m == MODE_RESULT) begin
            mx = mc[0];
            for (int i = 1; i < 3; i++) if (mc[i] > mx) mx = mc[i];
            for (int i = 0; i < 3; i++) mf[i] = (mx > 0) && (mc[i] == mx);
        end else begin
            for (int i = 0; i < 3; i++) mf[i] = 1'b0;
            pressed = 0;
            for (int i = 0; i < 3; i++) if (v[i]) pressed++;
            if (m == MODE_VOTE && pressed == 1) begin
                for (int i = 0; i < 3; i++)
                    if (v[i] && mc[i] < MAXC) mc[i] = mc[i] + 1;
            end
        end
    endfunction

    task automatic apply(input bit r, input logic [1:0] m, input logic [2:0] v);
        obs_t e;
        reset          = r;
        mode           = m;
        in_candidate_1 = v[0];
        in_candidate_2 = v[1];
        in_candidate_3 = v[2];
        model_step(r, m, v);
        e.c1 = W'(mc[0]);
        e.c2 = W'(mc[1]);
        e.c3 = W'(mc[2]);
        e.f1 = mf[0];
        e.f2 = mf[1];
        e.f3 = mf[2];
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: after each edge the DUT presents a fresh output set.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.c1 = count_candidate_1;
                a.c2 = count_candidate_2;
                a.c3 = count_candidate_3;
                a.f1 = candidate_1;
                a.f2 = candidate_2;
                a.f3 = candidate_3;
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs vec %0d t=%0t: got c=%0d/%0d/%0d f=%b%b%b, expected c=%0d/%0d/%0d f=%b%b%b",
                             vectors, $time, a.c1, a.c2, a.c3, a.f1, a.f2, a.f3,
                             e.c1, e.c2, e.c3, e.f1, e.f2, e.f3);
                end
            end
        end
    end

    initial begin
        int          seq[16] = '{1, 3, 2, 1, 2, 2, 2, 3, 1, 1, 2, 3, 3, 2, 1, 3};
        int          tie[5]  = '{1, 2, 1, 2, 3};
        logic [2:0]  v;
        logic [1:0]  m;
        int          sel;
        bit          r;

        // Reset in idle.
        apply(1'b1, MODE_IDLE, 3'b000);
        apply(1'b0, MODE_IDLE, 3'b000);

        // Ordered single-button vote sequence -> 5/6/5.
        foreach (seq[i]) apply(1'b0, MODE_VOTE, 3'(1 << (seq[i] - 1)));
        apply(1'b0, MODE_RESULT, 3'b000);
        apply(1'b0, MODE_RESULT, 3'b111);
        apply(1'b0, MODE_IDLE, 3'b000);

        // Idle and reserved modes ignore buttons.
        apply(1'b0, MODE_IDLE, 3'b001);
        apply(1'b0, 2'd3, 3'b010);

        // Double press is void; held button counts every cycle.
        apply(1'b0, MODE_VOTE, 3'b011);
        apply(1'b0, MODE_VOTE, 3'b111);
        repeat (3) apply(1'b0, MODE_VOTE, 3'b100);
        apply(1'b0, MODE_RESULT, 3'b000);
        apply(1'b0, MODE_VOTE, 3'b000);

        // Tie 2/2/1 then empty field.
        apply(1'b1, MODE_IDLE, 3'b000);
        foreach (tie[i]) apply(1'b0, MODE_VOTE, 3'(1 << (tie[i] - 1)));
        repeat (2) apply(1'b0, MODE_RESULT, 3'b000);
        apply(1'b1, MODE_IDLE, 3'b000);
        repeat (2) apply(1'b0, MODE_RESULT, 3'b000);

        // Saturation, then reset during an active vote.
        repeat (300) apply(1'b0, MODE_VOTE, 3'b001);
        apply(1'b0, MODE_VOTE, 3'b010);
        apply(1'b0, MODE_RESULT, 3'b000);
        apply(1'b1, MODE_VOTE, 3'b010);
        apply(1'b0, MODE_IDLE, 3'b000);

        // Random mix weighted towards voting.
        for (int n = 0; n < 1500; n++) begin
            r   = ($urandom_range(63) == 0);
            sel = $urandom_range(9);
            if (sel <= 5)      m = MODE_VOTE;
            else if (sel <= 7) m = MODE_RESULT;
            else if (sel == 8) m = MODE_IDLE;
            else               m = 2'd3;
            if ($urandom_range(1) == 1) v = 3'(1 << $urandom_range(2));
            else                        v = 3'($urandom_range(7));
            apply(r, m, v);
        end

        // Every pushed expectation must have been consumed by the monitor.
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
